// File: rtl/seven_segment_driver.sv
// Eight-digit multiplexed seven-segment driver.
// One digit lit at a time; values latched once per full scan.
module seven_segment_driver #(
  parameter int CLK_FREQUENCY          = 100_000_000,
  parameter int MIN_SEGMENT_DISPLAY_US = 10_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        display_en,
  input  logic [31:0] display_val,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [7:0]  anode,
  output logic        scan_done
);

  localparam int SEGMENT_CLOCKS =
    CLK_FREQUENCY / 1_000_000 * MIN_SEGMENT_DISPLAY_US;
  localparam int CW =
    (SEGMENT_CLOCKS > 1) ? $clog2(SEGMENT_CLOCKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SEGMENT_CLOCKS - 1);

  generate
    if (SEGMENT_CLOCKS < 1) begin : g_bad_cfg
      $fatal(1, "SEGMENT_CLOCKS must be at least 1");
    end
  endgenerate

  logic          running;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   sh_val;
  logic [7:0]    sh_dp;
  logic [7:0]    sh_blk;

  logic          start;
  logic          wrap;
  logic          load;
  logic [CW-1:0] nxt_cnt;
  logic [2:0]    nxt_idx;
  logic [31:0]   nxt_val;
  logic [7:0]    nxt_dp;
  logic [7:0]    nxt_blk;
  logic [3:0]    nib;
  logic [6:0]    seg_n;
  logic [7:0]    an_n;
  logic          dp_n;
  logic          done_n;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Outputs are decoded from next-state so they land on the same edge.
  always_comb begin
    start   = display_en & ~running;
    wrap    = running & (cnt == LAST);
    load    = start | (wrap & (idx == 3'd7));
    nxt_cnt = (start | wrap) ? '0 : cnt + 1'b1;
    nxt_idx = idx;
    if (start)
      nxt_idx = 3'd0;
    else if (wrap)
      nxt_idx = idx + 3'd1;
    nxt_val = load ? display_val : sh_val;
    nxt_dp  = load ? dp_in : sh_dp;
    nxt_blk = load ? blank : sh_blk;
    nib     = nxt_val[{nxt_idx, 2'b00} +: 4];
    an_n    = ~(8'b1 << nxt_idx);
    seg_n   = nxt_blk[nxt_idx] ? 7'h7F : hex7(nib);
    dp_n    = ~(nxt_dp[nxt_idx] & ~nxt_blk[nxt_idx]);
    done_n  = wrap & (idx == 3'd7);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running   <= 1'b0;
      cnt       <= '0;
      idx       <= 3'd0;
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_blk    <= '0;
      anode     <= 8'hFF;
      segments  <= 7'h7F;
      dp        <= 1'b1;
      scan_done <= 1'b0;
    end else if (!display_en) begin
      running   <= 1'b0;
      cnt       <= '0;
      idx       <= 3'd0;
      anode     <= 8'hFF;
      segments  <= 7'h7F;
      dp        <= 1'b1;
      scan_done <= 1'b0;
    end else begin
      running   <= 1'b1;
      cnt       <= nxt_cnt;
      idx       <= nxt_idx;
      sh_val    <= nxt_val;
      sh_dp     <= nxt_dp;
      sh_blk    <= nxt_blk;
      anode     <= an_n;
      segments  <= seg_n;
      dp        <= dp_n;
      scan_done <= done_n;
    end
  end

endmodule

// File: tb/tb_seven_segment_driver.sv
// Bench for seven_segment_driver: per-cycle scoreboard
// plus hex-table sweep and reset/enable corner cases.
module tb_seven_segment_driver;

  localparam int SC   = 10;
  localparam int SCAN = 8 * SC;

  logic        clk = 1'b0;
  logic        rst;
  logic        display_en;
  logic [31:0] display_val;
  logic [7:0]  dp_in;
  logic [7:0]  blank;
  logic [6:0]  segments;
  logic        dp;
  logic [7:0]  anode;
  logic        scan_done;

  seven_segment_driver #(
    .CLK_FREQUENCY(1_000_000),
    .MIN_SEGMENT_DISPLAY_US(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .display_en(display_en),
    .display_val(display_val),
    .dp_in(dp_in),
    .blank(blank),
    .segments(segments),
    .dp(dp),
    .anode(anode),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } hex_t;

  typedef struct {
    logic [7:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       done;
  } exp_t;

  hex_t hex_tab[16];
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   done_seen = 0;

  bit          m_on = 1'b0;
  int          m_t = 0;
  logic [31:0] s_val = '0;
  logic [7:0]  s_dp = '0;
  logic [7:0]  s_blk = '0;

  function automatic logic [6:0] lut(input logic [3:0] n);
    logic [6:0] r;
    r = 7'h00;
    for (int k = 0; k < 16; k++)
      if (hex_tab[k].nib == n) r = hex_tab[k].seg;
    return r;
  endfunction

  // Reference: position within an 80-clock scan, digit = pos / 10.
  task automatic model_step();
    exp_t e;
    int d;
    e.anode = 8'hFF;
    e.seg   = 7'h7F;
    e.dp    = 1'b1;
    e.done  = 1'b0;
    if (rst) begin
      m_on = 1'b0;
      m_t = 0;
      s_val = '0;
      s_dp = '0;
      s_blk = '0;
    end else if (!display_en) begin
      m_on = 1'b0;
      m_t = 0;
    end else begin
      e.done = m_on && (m_t == SCAN - 1);
      m_t = m_on ? (m_t + 1) % SCAN : 0;
      m_on = 1'b1;
      if (m_t == 0) begin
        s_val = display_val;
        s_dp = dp_in;
        s_blk = blank;
      end
      d = m_t / SC;
      e.anode = ~(8'h01 << d);
      if (s_blk[d]) begin
        e.seg = 7'h7F;
        e.dp = 1'b1;
      end else begin
        e.seg = lut(s_val[4*d +: 4]);
        e.dp = ~s_dp[d];
      end
    end
    q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    int zeros;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (anode !== e.anode || segments !== e.seg ||
          dp !== e.dp || scan_done !== e.done) begin
        bad++;
        $display("FAIL cycle t=%0t got an=%h seg=%b dp=%b done=%b want an=%h seg=%b dp=%b done=%b",
                 $time, anode, segments, dp, scan_done,
                 e.anode, e.seg, e.dp, e.done);
      end
      zeros = 0;
      for (int b = 0; b < 8; b++)
        if (anode[b] == 1'b0) zeros++;
      total++;
      if (zeros > 1) begin
        bad++;
        $display("FAIL onehot t=%0t got an=%h want at most one low", $time, anode);
      end
      if (scan_done === 1'b1) done_seen++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic check_dark(input string name);
    total++;
    if (anode !== 8'hFF || segments !== 7'h7F ||
        dp !== 1'b1 || scan_done !== 1'b0) begin
      bad++;
      $display("FAIL %s got an=%h seg=%b dp=%b done=%b want an=ff seg=1111111 dp=1 done=0",
               name, anode, segments, dp, scan_done);
    end
  endtask

  initial begin
    hex_tab = '{
      '{4'h0, 7'b0000001}, '{4'h1, 7'b1001111},
      '{4'h2, 7'b0010010}, '{4'h3, 7'b0000110},
      '{4'h4, 7'b1001100}, '{4'h5, 7'b0100100},
      '{4'h6, 7'b0100000}, '{4'h7, 7'b0001111},
      '{4'h8, 7'b0000000}, '{4'h9, 7'b0000100},
      '{4'hA, 7'b0001000}, '{4'hB, 7'b1100000},
      '{4'hC, 7'b0110001}, '{4'hD, 7'b1000010},
      '{4'hE, 7'b0110000}, '{4'hF, 7'b0111000}
    };
    rst = 1'b0;
    display_en = 1'b0;
    display_val = '0;
    dp_in = '0;
    blank = '0;
    #1 rst = 1'b1;
    #1 check_dark("reset");

    // Full scans of 89ABCDEF straight out of reset.
    display_en = 1'b1;
    display_val = 32'h89ABCDEF;
    @(negedge clk);
    #2 rst = 1'b0;
    done_seen = 0;
    cycles(170);
    total++;
    if (done_seen != 2) begin
      bad++;
      $display("FAIL scan_done_count got %0d want 2", done_seen);
    end

    // Value change mid-scan must wait for the next scan.
    display_en = 1'b0;
    cycles(1);
    display_val = 32'h0;
    display_en = 1'b1;
    cycles(35);
    display_val = 32'h11111111;
    cycles(130);

    // Blanking and decimal points.
    display_val = 32'h01234567;
    dp_in = 8'h81;
    blank = 8'h0F;
    cycles(170);

    // Enable dropped during digit 5, then restored.
    dp_in = 8'h00;
    blank = 8'h00;
    display_en = 1'b0;
    cycles(1);
    display_en = 1'b1;
    cycles(55);
    display_en = 1'b0;
    cycles(1);
    check_dark("en_drop");
    cycles(3);
    display_en = 1'b1;
    cycles(25);

    // Asynchronous reset during digit 2.
    display_en = 1'b0;
    cycles(1);
    display_en = 1'b1;
    cycles(25);
    rst = 1'b1;
    #1 check_dark("async_rst");
    cycles(2);
    rst = 1'b0;
    cycles(30);

    // Every hex glyph on digit 0 right after enable.
    for (int i = 0; i < 16; i++) begin
      display_en = 1'b0;
      cycles(1);
      display_en = 1'b1;
      display_val = {8{hex_tab[i].nib}};
      cycles(1);
      total++;
      if (anode !== 8'hFE || segments !== hex_tab[i].seg) begin
        bad++;
        $display("FAIL glyph_%h got an=%h seg=%b want an=fe seg=%b",
                 hex_tab[i].nib, anode, segments, hex_tab[i].seg);
      end
      cycles(3);
    end

    cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
